cache_replacement_ctrl: RTL and testbench

Parametrised victim-selection and replacement-state block for the set-associative cache. It selects a victim way and supports FIFO, tree pseudo-LRU and LFSR-random policies. Invalid ways are always filled before any valid way is evicted. Victim selection (lookup) is separated from the state update (fill/hit commit), so the cache controller decides when the replacement state advances.

---
 rtl/cache_repl_pkg.sv | 33 +++
 rtl/cache_replacement_ctrl_plru_tree.sv | 39 +++
 rtl/cache_replacement_ctrl.sv | 146 ++++++++++++++
 tb/tb_cache_replacement_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_repl_pkg.sv
// Shared constants and helpers for the cache replacement controller.
package cache_repl_pkg;

    // Replacement policy selectors for the POLICY parameter.
    localparam int unsigned REPL_FIFO   = 0;
    localparam int unsigned REPL_PLRU   = 1;
    localparam int unsigned REPL_RANDOM = 2;

    // Global LFSR for the random policy: x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    // A set bit in LFSR_TAPS marks a register bit that feeds the XOR into bit 15.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Widest supported associativity; narrower way masks are padded with 1s (valid).
    localparam int unsigned MAX_WAYS  = 16;
    localparam int unsigned MAX_WAY_W = 4;

    // Index of the lowest-numbered invalid way, or 0 when every way is valid.
    function automatic logic [MAX_WAY_W-1:0] lowest_invalid_way(input logic [MAX_WAYS-1:0] valid);
        logic [MAX_WAY_W-1:0] way;
        logic                 found;
        way   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_WAYS; i++) begin
            if (!valid[i] && !found) begin
                way   = MAX_WAY_W'(i);
                found = 1'b1;
            end
        end
        return way;
    endfunction

endpackage

// File: rtl/cache_replacement_ctrl_plru_tree.sv
// Tree pseudo-LRU helper: victim walk and touch update for one set's tree.
// Tree bits are heap-ordered: node 0 is the root, children of n are 2n+1 and 2n+2.
module plru_tree_logic #(
    parameter  int unsigned NUM_WAYS = 4,
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] tree,
    input  logic [WAY_W-1:0]    touch_way,
    output logic [WAY_W-1:0]    victim,
    output logic [NUM_WAYS-2:0] next_tree
);

    // Walk from the root: a 0 bit descends into the lower half, a 1 bit into the upper half.
    always_comb begin
        logic [WAY_W-1:0] node;
        logic             dir;
        victim = '0;
        node   = '0;
        for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
            dir                    = tree[node];
            victim[WAY_W-1-lvl]    = dir;
            node                   = (node << 1) + WAY_W'(1) + WAY_W'(dir);
        end
    end

    // Every node on the touched way's path is turned to point away from that way.
    always_comb begin
        logic [WAY_W-1:0] node;
        logic             dir;
        next_tree = tree;
        node      = '0;
        for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
            dir             = touch_way[WAY_W-1-lvl];
            next_tree[node] = ~dir;
            node            = (node << 1) + WAY_W'(1) + WAY_W'(dir);
        end
    end

endmodule

// File: rtl/cache_replacement_ctrl.sv
// Victim selection and replacement state for a set-associative cache.
// Lookup returns a victim one cycle later; fills and hits commit state separately.
module cache_replacement_ctrl
    import cache_repl_pkg::*;
#(
    parameter  int unsigned NUM_SETS = 32,
    parameter  int unsigned NUM_WAYS = 4,
    parameter  int unsigned POLICY   = REPL_FIFO,
    localparam int unsigned IDX_W    = $clog2(NUM_SETS),
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lookup_valid,
    input  logic [IDX_W-1:0]    lookup_index,
    input  logic [NUM_WAYS-1:0] way_valid,
    output logic                victim_valid,
    output logic [WAY_W-1:0]    victim_way,
    input  logic                fill_valid,
    input  logic [IDX_W-1:0]    fill_index,
    input  logic [WAY_W-1:0]    fill_way,
    input  logic                hit_valid,
    input  logic [IDX_W-1:0]    hit_index,
    input  logic [WAY_W-1:0]    hit_way
);

    if (NUM_WAYS < 2 || NUM_WAYS > MAX_WAYS || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
        $error("cache_replacement_ctrl: NUM_WAYS must be a power of two in 2..16");
    end

    if (NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0) begin : g_bad_sets
        $error("cache_replacement_ctrl: NUM_SETS must be a power of two >= 2");
    end

    logic [MAX_WAYS-1:0]  valid_ext;
    logic [MAX_WAY_W-1:0] invalid_way;
    logic [WAY_W-1:0]     policy_victim;
    logic [WAY_W-1:0]     lookup_victim;

    // Invalid ways always win over the policy choice.
    always_comb begin
        valid_ext                 = '1;
        valid_ext[NUM_WAYS-1:0]   = way_valid;
        invalid_way               = lowest_invalid_way(valid_ext);
        lookup_victim             = (&way_valid) ? policy_victim : invalid_way[WAY_W-1:0];
    end

    // Register one result per lookup; victim_valid is a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            victim_valid <= 1'b0;
            victim_way   <= '0;
        end else begin
            victim_valid <= lookup_valid;
            if (lookup_valid) begin
                victim_way <= lookup_victim;
            end
        end
    end

    if (POLICY == REPL_FIFO) begin : g_fifo
        logic [WAY_W-1:0] fifo_ptr [NUM_SETS];

        // Pointer advances only when the fill lands on the way it names; invalid-slot fills leave it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int unsigned s = 0; s < NUM_SETS; s++) begin
                    fifo_ptr[s] <= '0;
                end
            end else if (fill_valid && fill_way == fifo_ptr[fill_index]) begin
                fifo_ptr[fill_index] <= fifo_ptr[fill_index] + WAY_W'(1);
            end
        end

        assign policy_victim = fifo_ptr[lookup_index];

    end else if (POLICY == REPL_PLRU) begin : g_plru
        logic [NUM_WAYS-2:0] plru_tree [NUM_SETS];
        logic [NUM_WAYS-2:0] fill_next;
        logic [NUM_WAYS-2:0] hit_next;
        logic [NUM_WAYS-2:0] unused_lookup_next;
        logic [WAY_W-1:0]    unused_fill_victim;
        logic [WAY_W-1:0]    unused_hit_victim;

        plru_tree_logic #(.NUM_WAYS(NUM_WAYS)) u_lookup_tree (
            .tree      (plru_tree[lookup_index]),
            .touch_way ('0),
            .victim    (policy_victim),
            .next_tree (unused_lookup_next)
        );

        plru_tree_logic #(.NUM_WAYS(NUM_WAYS)) u_fill_tree (
            .tree      (plru_tree[fill_index]),
            .touch_way (fill_way),
            .victim    (unused_fill_victim),
            .next_tree (fill_next)
        );

        plru_tree_logic #(.NUM_WAYS(NUM_WAYS)) u_hit_tree (
            .tree      (plru_tree[hit_index]),
            .touch_way (hit_way),
            .victim    (unused_hit_victim),
            .next_tree (hit_next)
        );

        // Fill and hit both touch their sets; on a same-set collision the fill wins.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int unsigned s = 0; s < NUM_SETS; s++) begin
                    plru_tree[s] <= '0;
                end
            end else begin
                if (fill_valid) begin
                    plru_tree[fill_index] <= fill_next;
                end
                if (hit_valid && !(fill_valid && hit_index == fill_index)) begin
                    plru_tree[hit_index] <= hit_next;
                end
            end
        end

    end else if (POLICY == REPL_RANDOM) begin : g_random
        logic [15:0] lfsr;

        // Free-running Fibonacci LFSR; a maximal-length sequence from a non-zero seed never hits zero.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lfsr <= LFSR_SEED;
            end else begin
                lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
            end
        end

        assign policy_victim = lfsr[WAY_W-1:0];

    end else begin : g_bad_policy
        $error("cache_replacement_ctrl: illegal POLICY %0d", POLICY);
        assign policy_victim = '0;
    end

    // Inputs a given policy ignores are gathered here so they are visibly accounted for.
    logic unused_inputs;
    assign unused_inputs = ^{fill_valid, fill_index, fill_way, hit_valid, hit_index, hit_way,
                             lookup_index, invalid_way};

endmodule

// File: tb/tb_cache_replacement_ctrl.sv
// Directed bench for cache_replacement_ctrl: one instance per policy sharing stimulus.
module tb_cache_replacement_ctrl;
    import cache_repl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       lookup_valid;
    logic [4:0] lookup_index;
    logic [3:0] way_valid;
    logic       fill_valid;
    logic [4:0] fill_index;
    logic [1:0] fill_way;
    logic       hit_valid;
    logic [4:0] hit_index;
    logic [1:0] hit_way;

    logic       vv_fifo, vv_plru, vv_rand;
    logic [1:0] vw_fifo, vw_plru, vw_rand;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_replacement_ctrl #(.NUM_SETS(32), .NUM_WAYS(4), .POLICY(REPL_FIFO)) u_fifo (
        .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_index(lookup_index),
        .way_valid(way_valid), .victim_valid(vv_fifo), .victim_way(vw_fifo),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
        .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way)
    );

    cache_replacement_ctrl #(.NUM_SETS(32), .NUM_WAYS(4), .POLICY(REPL_PLRU)) u_plru (
        .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_index(lookup_index),
        .way_valid(way_valid), .victim_valid(vv_plru), .victim_way(vw_plru),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
        .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way)
    );

    cache_replacement_ctrl #(.NUM_SETS(32), .NUM_WAYS(4), .POLICY(REPL_RANDOM)) u_rand (
        .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_index(lookup_index),
        .way_valid(way_valid), .victim_valid(vv_rand), .victim_way(vw_rand),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
        .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way)
    );

    task automatic check_val(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lookup_valid = 1'b0;
        fill_valid   = 1'b0;
        hit_valid    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic lookup(input logic [4:0] idx, input logic [3:0] valid);
        lookup_index = idx;
        way_valid    = valid;
        lookup_valid = 1'b1;
        step();
        lookup_valid = 1'b0;
    endtask

    task automatic fill(input logic [4:0] idx, input logic [1:0] way);
        fill_index = idx;
        fill_way   = way;
        fill_valid = 1'b1;
        step();
        fill_valid = 1'b0;
    endtask

    task automatic hit(input logic [4:0] idx, input logic [1:0] way);
        hit_index = idx;
        hit_way   = way;
        hit_valid = 1'b1;
        step();
        hit_valid = 1'b0;
    endtask

    // Low two bits of the LFSR from 16'hACE1: ACE1,5670,AB38,559C,2ACE,1567,8AB3,4559,22AC
    int rand_exp [9] = '{1, 0, 0, 0, 2, 3, 3, 1, 0};
    int fifo_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset        = 1'b1;
        clear_inputs();
        lookup_index = '0;
        way_valid    = '0;
        fill_index   = '0;
        fill_way     = '0;
        hit_index    = '0;
        hit_way      = '0;
        #12;

        check_val("reset_vv_fifo", int'(vv_fifo), 0);
        check_val("reset_vw_fifo", int'(vw_fifo), 0);
        check_val("reset_vv_plru", int'(vv_plru), 0);
        check_val("reset_vw_plru", int'(vw_plru), 0);
        check_val("reset_vv_rand", int'(vv_rand), 0);
        check_val("reset_vw_rand", int'(vw_rand), 0);

        // RANDOM: lookups on every edge from the first edge after release; fills must not disturb it.
        lookup_index = 5'd0;
        way_valid    = 4'b1111;
        lookup_valid = 1'b1;
        #1;
        reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            fill_valid = (k >= 4);
            fill_index = 5'd0;
            fill_way   = 2'(k);
            step();
            check_val("rand_valid", int'(vv_rand), 1);
            check_val($sformatf("rand_seq%0d", k), int'(vw_rand), rand_exp[k]);
        end
        clear_inputs();
        step();
        check_val("rand_pulse_drop", int'(vv_rand), 0);

        do_reset();

        // Invalid-way preference under every policy.
        lookup(5'd5, 4'b1011);
        check_val("inv1011_fifo", int'(vw_fifo), 2);
        check_val("inv1011_plru", int'(vw_plru), 2);
        check_val("inv1011_rand", int'(vw_rand), 2);
        lookup(5'd5, 4'b0000);
        check_val("inv0000_fifo", int'(vw_fifo), 0);
        check_val("inv0000_plru", int'(vw_plru), 0);
        check_val("inv0000_rand", int'(vw_rand), 0);
        lookup(5'd5, 4'b1111);
        check_val("inv_ptr_kept", int'(vw_fifo), 0);
        check_val("inv_tree_kept", int'(vw_plru), 0);

        // FIFO round robin on set 5.
        for (int k = 0; k < 5; k++) begin
            lookup(5'd5, 4'b1111);
            check_val($sformatf("fifo_rr%0d", k), int'(vw_fifo), fifo_exp[k]);
            fill(5'd5, 2'(fifo_exp[k]));
        end

        // FIFO same-cycle lookup and fill on set 7 with pointer 2.
        fill(5'd7, 2'd0);
        fill(5'd7, 2'd1);
        lookup_index = 5'd7;
        way_valid    = 4'b1111;
        lookup_valid = 1'b1;
        fill_index   = 5'd7;
        fill_way     = 2'd2;
        fill_valid   = 1'b1;
        step();
        fill_valid = 1'b0;
        check_val("fifo_same_cycle", int'(vw_fifo), 2);
        step();
        lookup_valid = 1'b0;
        check_val("fifo_after_fill", int'(vw_fifo), 3);
        fill(5'd7, 2'd0);
        lookup(5'd7, 4'b1111);
        check_val("fifo_offptr_fill", int'(vw_fifo), 3);

        do_reset();

        // PLRU on set 3.
        hit(5'd3, 2'd0);
        hit(5'd3, 2'd1);
        hit(5'd3, 2'd2);
        hit(5'd3, 2'd3);
        lookup(5'd3, 4'b1111);
        check_val("plru_hits0123", int'(vw_plru), 0);
        hit(5'd3, 2'd0);
        lookup(5'd3, 4'b1111);
        check_val("plru_hit0", int'(vw_plru), 2);
        fill_index = 5'd3;
        fill_way   = 2'd2;
        fill_valid = 1'b1;
        hit_index  = 5'd3;
        hit_way    = 2'd0;
        hit_valid  = 1'b1;
        step();
        clear_inputs();
        lookup(5'd3, 4'b1111);
        check_val("plru_fill_wins", int'(vw_plru), 1);
        fill_index = 5'd4;
        fill_way   = 2'd0;
        fill_valid = 1'b1;
        hit_index  = 5'd3;
        hit_way    = 2'd1;
        hit_valid  = 1'b1;
        step();
        clear_inputs();
        lookup(5'd3, 4'b1111);
        check_val("plru_dual_hit", int'(vw_plru), 3);
        lookup(5'd4, 4'b1111);
        check_val("plru_dual_fill", int'(vw_plru), 2);

        // Asynchronous reset while a result is being presented.
        fill(5'd9, 2'd0);
        lookup(5'd9, 4'b1111);
        check_val("pre_rst_vv", int'(vv_fifo), 1);
        check_val("pre_rst_vw", int'(vw_fifo), 1);
        reset = 1'b1;
        #1;
        check_val("async_rst_vv_fifo", int'(vv_fifo), 0);
        check_val("async_rst_vv_plru", int'(vv_plru), 0);
        check_val("async_rst_vv_rand", int'(vv_rand), 0);
        check_val("async_rst_vw_fifo", int'(vw_fifo), 0);
        step();
        reset = 1'b0;
        for (int s = 0; s < 32; s++) begin
            lookup(5'(s), 4'b1111);
            check_val($sformatf("post_rst_fifo_set%0d", s), int'(vw_fifo), 0);
            check_val($sformatf("post_rst_plru_set%0d", s), int'(vw_plru), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
